stage_renderer: RTL and testbench
=================================

Name: stage_renderer

Overview:
- Downstream consumer of the bomb/stage block: walks the 11x11 playfield, 16x16 px tiles, origin (72,32).
- For each pixel it drives the shared query position, samples tile id, explosion flag and bomb slots, picks a colour and emits one VGA-adapter plot per pixel.
- Redraws one full frame per start pulse; the top level triggers it after game-state updates.

Parameters:
- ORIGIN_X, 72, playfield left edge in pixels.
- ORIGIN_Y, 32, playfield top edge in pixels.
- C_FLOOR, 9'o070, colour for tile id 0.
- C_WALL, 9'o444, colour for tile id 1.
- C_SOFT, 9'o631, colour for tile id 2.
- C_POWER, 9'o077, colour for tile id >= 3.
- C_BOMB, 9'o000, bomb body colour.
- C_EXPL, 9'o740, explosion colour.

Ports:
- clk  in  1  50 MHz clock.
- reset  in  1  Synchronous, active-high.
- start  in  1  Begin a frame; sampled only in IDLE.
- qX  out  9  Query X pixel to bomb block.
- qY  out  8  Query Y pixel to bomb block.
- bomb_id  out  3  Bomb slot select, 0..5.
- map_tile_id  in  4  Tile id at (qX,qY), combinational from qX/qY.
- has_explosion  in  1  Explosion at (qX,qY), combinational.
- bomb_info  in  18  {bY[7:0], bX[8:0], enabled} for bomb_id, combinational.
- vga_x  out  9  Plot X.
- vga_y  out  8  Plot Y.
- vga_colour  out  9  RGB333 plot colour.
- vga_plot  out  1  Write strobe, one pixel per high cycle.
- busy  out  1  High from the cycle after start is accepted until done.
- done  out  1  One-cycle pulse after the last pixel's plot.

Behaviour:
- Clock and reset: clk rising edge; reset synchronous, active-high.
- Reset values: state IDLE; qX=ORIGIN_X, qY=ORIGIN_Y; bomb_id=0; vga_x=0, vga_y=0, vga_colour=0; vga_plot=0, busy=0, done=0.
- Reset mid-frame: abort immediately with the same values; no further plots.
- Counters: tile tx, ty in 0..10, row-major. Pixel px, py in 0..15, row-major inside the tile.
- Query position: qX = ORIGIN_X + 16*tx + px; qY = ORIGIN_Y + 16*ty + py. Registered outputs.
- IDLE: start=1 moves to BSCAN with tx=ty=0 and busy=1. start is ignored in every other state.
- BSCAN (7 cycles):
  - Cycles 0..5 drive bomb_id=k and qX/qY = tile origin.
  - Each cycle after the first samples bomb_info for the previous id.
  - tile_bomb is set if any slot has enabled=1 and bX == qX and bY == qY (tile origin).
  - tile_bomb is cleared on entry to BSCAN.
- PIXEL (256 cycles):
  - Drive every px/py in order, one per cycle.
  - Pipeline: the cycle after a coordinate is driven, sample the inputs and register the plot outputs.
  - vga_plot=1, with vga_x/vga_y equal to the coordinate driven one cycle earlier.
- Colour priority:
  1. has_explosion gives C_EXPL.
  2. Otherwise, tile_bomb with px and py both in 4..11 gives C_BOMB.
  3. Otherwise, tile colour by map_tile_id: 0 C_FLOOR, 1 C_WALL, 2 C_SOFT, 3..15 C_POWER.
- DRAIN (1 cycle):
  - Emits the plot for pixel (15,15).
  - Then advances the tile: tx++; at tx=10, wrap to 0 and ty++.
  - After tile (10,10), goes to FINISH; otherwise back to BSCAN.
- vga_plot is 0 in BSCAN cycles, except the first BSCAN cycle after DRAIN, which carries no plot either (DRAIN already emitted it).
- FINISH: done=1 and busy=0 for one cycle, then IDLE. done and start on the same cycle: start is ignored.
- Timing: frame = 121*(7+256+1) = 31944 cycles from start-accept to done; exactly 30976 plots.
- Widths: qX fits 9 bits (max 72+175=247); qY fits 8 bits (max 207). Tile-origin sums are computed in 9 bits, with no wrap.
- Inputs are treated as stable for the frame. Mid-frame stage changes appear on whichever pixels are sampled after the change; no atomic snapshot.

Test Plan:
- Reset, then start with all tiles 0, no bombs, no explosion -> 30976 plots all 9'o070; first plot (72,32), last (247,207); done exactly 31944 cycles after start-accept; busy high throughout.
- Tile (1,1)=1, tile (2,0)=2 -> pixels x 88..103, y 48..63 are 9'o444; x 104..119, y 32..47 are 9'o631; tile id 7 anywhere gives 9'o077.
- bomb_info slot 4 = {8'd48, 9'd88, 1'b1} -> tile (1,1) pixels x 92..99, y 52..59 are 9'o000, the rest of the tile is floor; slot enabled=0 gives no bomb pixels.
- has_explosion forced 1 when qX=100 and qY=50, with a bomb on that tile -> plot (100,50) is 9'o740.
- Reset asserted 500 cycles into a frame -> next cycle vga_plot=0, busy=0, no done pulse; a new start restarts at (72,32).
- start pulsed again while busy, and on the done cycle -> ignored; only one frame of 30976 plots and one done pulse.

Source files
------------

// File: rtl/stage_renderer.sv
// stage_renderer: walks the 11x11 playfield (16x16 px tiles) and emits one
// VGA-adapter plot per pixel. For each tile it first scans the six bomb
// slots at the tile origin, then sweeps the 256 pixels with a one-cycle
// query->plot pipeline, then drains the last plot before moving on.
//
// state  | meaning
// IDLE   | waiting for start
// BSCAN  | 7 cycles: bomb slots 0..5 compared against the tile origin
// PIXEL  | 256 cycles: drive each pixel query, plot the previous one
// DRAIN  | plot pixel (15,15), advance to the next tile
// FINISH | one-cycle done pulse
module stage_renderer #(
  parameter logic [8:0] ORIGIN_X = 9'd72,
  parameter logic [7:0] ORIGIN_Y = 8'd32,
  parameter logic [8:0] C_FLOOR  = 9'o070,
  parameter logic [8:0] C_WALL   = 9'o444,
  parameter logic [8:0] C_SOFT   = 9'o631,
  parameter logic [8:0] C_POWER  = 9'o077,
  parameter logic [8:0] C_BOMB   = 9'o000,
  parameter logic [8:0] C_EXPL   = 9'o740
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [8:0]  qX,
  output logic [7:0]  qY,
  output logic [2:0]  bomb_id,
  input  logic [3:0]  map_tile_id,
  input  logic        has_explosion,
  input  logic [17:0] bomb_info,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [8:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BSCAN,
    S_PIXEL,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam logic [3:0] LAST_TILE = 4'd10;
  localparam logic [2:0] LAST_SCAN = 3'd6;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_tx, r_ty, r_px, r_py;
  logic [3:0] w_tx_nxt, w_ty_nxt, w_px_nxt, w_py_nxt;
  logic [2:0] r_scan, w_scan_nxt;
  logic       r_tile_bomb;
  logic [8:0] w_qx_sum, w_qy_sum;
  logic [8:0] w_colour;
  logic       w_bomb_hit;
  logic       w_in_bomb_area;

  // Next-state and counter advance for the tile/pixel walk.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_ty_nxt    = r_ty;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_scan_nxt  = r_scan;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_BSCAN;
          w_tx_nxt    = 4'd0;
          w_ty_nxt    = 4'd0;
          w_px_nxt    = 4'd0;
          w_py_nxt    = 4'd0;
          w_scan_nxt  = 3'd0;
        end
      end
      S_BSCAN: begin
        if (r_scan == LAST_SCAN) begin
          w_state_nxt = S_PIXEL;
          w_px_nxt    = 4'd0;
          w_py_nxt    = 4'd0;
        end else begin
          w_scan_nxt = r_scan + 3'd1;
        end
      end
      S_PIXEL: begin
        w_px_nxt = r_px + 4'd1;
        if (r_px == 4'd15) begin
          w_py_nxt = r_py + 4'd1;
          if (r_py == 4'd15) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_scan_nxt = 3'd0;
        w_px_nxt   = 4'd0;
        w_py_nxt   = 4'd0;
        if (r_tx == LAST_TILE) begin
          w_tx_nxt = 4'd0;
          if (r_ty == LAST_TILE) begin
            w_ty_nxt    = 4'd0;
            w_state_nxt = S_FINISH;
          end else begin
            w_ty_nxt    = r_ty + 4'd1;
            w_state_nxt = S_BSCAN;
          end
        end else begin
          w_tx_nxt    = r_tx + 4'd1;
          w_state_nxt = S_BSCAN;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and walk counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tx    <= 4'd0;
      r_ty    <= 4'd0;
      r_px    <= 4'd0;
      r_py    <= 4'd0;
      r_scan  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_ty    <= w_ty_nxt;
      r_px    <= w_px_nxt;
      r_py    <= w_py_nxt;
      r_scan  <= w_scan_nxt;
    end
  end

  // Query position is derived from the next counters so qX/qY are registered.
  assign w_qx_sum = ORIGIN_X + {1'b0, w_tx_nxt, 4'b0000} + {5'b00000, w_px_nxt};
  assign w_qy_sum = {1'b0, ORIGIN_Y} + {1'b0, w_ty_nxt, 4'b0000} + {5'b00000, w_py_nxt};

  // Registered query position and bomb slot select.
  always_ff @(posedge clk) begin
    if (reset) begin
      qX      <= ORIGIN_X;
      qY      <= ORIGIN_Y;
      bomb_id <= 3'd0;
    end else begin
      qX      <= w_qx_sum;
      qY      <= w_qy_sum[7:0];
      bomb_id <= (w_state_nxt == S_BSCAN && w_scan_nxt < LAST_SCAN) ? w_scan_nxt : 3'd0;
    end
  end

  assign w_bomb_hit = bomb_info[0] && (bomb_info[9:1] == qX) && (bomb_info[17:10] == qY);

  // Accumulate the per-tile bomb flag while slots 0..5 are presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tile_bomb <= 1'b0;
    end else if (r_state == S_BSCAN) begin
      if (r_scan < LAST_SCAN && w_bomb_hit) begin
        r_tile_bomb <= 1'b1;
      end
    end else if (w_state_nxt == S_BSCAN) begin
      r_tile_bomb <= 1'b0;
    end
  end

  assign w_in_bomb_area = (r_px >= 4'd4) && (r_px <= 4'd11) &&
                          (r_py >= 4'd4) && (r_py <= 4'd11);

  // Colour pick: explosion over bomb body over tile colour.
  always_comb begin
    w_colour = C_POWER;
    case (map_tile_id)
      4'd0:    w_colour = C_FLOOR;
      4'd1:    w_colour = C_WALL;
      4'd2:    w_colour = C_SOFT;
      default: w_colour = C_POWER;
    endcase
    if (r_tile_bomb && w_in_bomb_area) begin
      w_colour = C_BOMB;
    end
    if (has_explosion) begin
      w_colour = C_EXPL;
    end
  end

  // Plot outputs lag the query by one cycle; busy/done follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_x      <= 9'd0;
      vga_y      <= 8'd0;
      vga_colour <= 9'd0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_plot <= (r_state == S_PIXEL);
      if (r_state == S_PIXEL) begin
        vga_x      <= qX;
        vga_y      <= qY;
        vga_colour <= w_colour;
      end
      busy <= (w_state_nxt == S_BSCAN) || (w_state_nxt == S_PIXEL) ||
              (w_state_nxt == S_DRAIN);
      done <= (w_state_nxt == S_FINISH);
    end
  end

endmodule

// File: tb/tb_stage_renderer.sv
// Bench for stage_renderer: a small stage model answers the renderer's
// queries, a negedge monitor checks plot order and colour against an
// independent per-pixel colour model, and directed frames cover the
// empty field, tile/bomb/explosion colours, ignored starts and mid-frame reset.
module tb_stage_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  qX;
  logic [7:0]  qY;
  logic [2:0]  bomb_id;
  logic [3:0]  map_tile_id;
  logic        has_explosion;
  logic [17:0] bomb_info;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  localparam int FRAME_CYC   = 31944;
  localparam int FRAME_PLOTS = 30976;

  int cyc = 0;
  int cfg = 0;
  int n_total = 0;
  int n_bad = 0;

  int n_plots = 0;
  int n_col_err = 0;
  int n_ord_err = 0;
  int n_dones = 0;
  int seq = 0;
  int last_x = 0;
  int last_y = 0;
  logic [8:0] img [0:255][0:255];

  stage_renderer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .qX            (qX),
    .qY            (qY),
    .bomb_id       (bomb_id),
    .map_tile_id   (map_tile_id),
    .has_explosion (has_explosion),
    .bomb_info     (bomb_info),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .busy          (busy),
    .done          (done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] tile_of(input int c, input int tx, input int ty);
    if (c == 1) begin
      if (tx == 1 && ty == 1) return 4'd1;
      if (tx == 2 && ty == 0) return 4'd2;
      if (tx == 5 && ty == 5) return 4'd7;
    end
    return 4'd0;
  endfunction

  // Slot 0: enabled but one pixel off tile (5,4); slot 2: disabled on tile (6,6);
  // slot 4: enabled bomb on tile (3,2).
  function automatic logic [17:0] slot_of(input int c, input int id);
    if (c == 1) begin
      if (id == 0) return {8'd96, 9'd153, 1'b1};
      if (id == 2) return {8'd128, 9'd168, 1'b0};
      if (id == 4) return {8'd64, 9'd120, 1'b1};
    end
    return 18'd0;
  endfunction

  function automatic logic expl_at(input int c, input int x, input int y);
    return (c == 1) && (x == 124) && (y == 68);
  endfunction

  function automatic int colour_of(input int c, input int x, input int y);
    int tx, ty, px, py, ox, oy;
    logic bomb;
    logic [17:0] s;
    tx = (x - 72) / 16;
    ty = (y - 32) / 16;
    px = (x - 72) % 16;
    py = (y - 32) % 16;
    ox = 72 + 16 * tx;
    oy = 32 + 16 * ty;
    if (expl_at(c, x, y)) return 9'o740;
    bomb = 1'b0;
    for (int id = 0; id < 6; id++) begin
      s = slot_of(c, id);
      if (s[0] && int'(s[9:1]) == ox && int'(s[17:10]) == oy) bomb = 1'b1;
    end
    if (bomb && px >= 4 && px <= 11 && py >= 4 && py <= 11) return 9'o000;
    case (tile_of(c, tx, ty))
      4'd0:    return 9'o070;
      4'd1:    return 9'o444;
      4'd2:    return 9'o631;
      default: return 9'o077;
    endcase
  endfunction

  function automatic int seq_x(input int s);
    return 72 + 16 * ((s / 256) % 11) + (s % 256) % 16;
  endfunction

  function automatic int seq_y(input int s);
    return 32 + 16 * ((s / 256) / 11) + (s % 256) / 16;
  endfunction

  // Stage model: combinational answers to the renderer's queries.
  always_comb begin
    map_tile_id   = tile_of(cfg, (int'(qX) - 72) / 16, (int'(qY) - 32) / 16);
    has_explosion = expl_at(cfg, int'(qX), int'(qY));
    bomb_info     = slot_of(cfg, int'(bomb_id));
  end

  // Plot monitor.
  always @(negedge clk) begin
    if (done) n_dones <= n_dones + 1;
    if (vga_plot) begin
      n_plots <= n_plots + 1;
      if (int'(vga_x) != seq_x(seq) || int'(vga_y) != seq_y(seq)) n_ord_err <= n_ord_err + 1;
      if (int'(vga_colour) != colour_of(cfg, int'(vga_x), int'(vga_y))) n_col_err <= n_col_err + 1;
      if (vga_x < 9'd256) img[vga_x[7:0]][vga_y] <= vga_colour;
      last_x <= int'(vga_x);
      last_y <= int'(vga_y);
      seq <= (seq == FRAME_PLOTS - 1) ? 0 : seq + 1;
    end else if (!busy) begin
      seq <= 0;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(output int a);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = cyc;
    check_eq("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int a, input string tag);
    int gaps;
    logic seen;
    gaps = 0;
    seen = 1'b0;
    for (int i = 0; i < FRAME_CYC + 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else if (!busy) begin
        gaps++;
      end
    end
    check_eq({tag, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check_eq({tag, "_latency"}, cyc - a, FRAME_CYC);
      check_eq({tag, "_busy_gaps"}, gaps, 0);
      check_eq({tag, "_busy_on_done"}, int'(busy), 0);
    end
  endtask

  task automatic wait_first_plot(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (vga_plot) seen = 1'b1;
    end
    check_eq({tag, "_plot_seen"}, int'(seen), 1);
    if (seen) begin
      check_eq({tag, "_x"}, int'(vga_x), 72);
      check_eq({tag, "_y"}, int'(vga_y), 32);
    end
  endtask

  initial begin
    int a, p0, c0, o0, d0, busy_hi;
    reset = 1'b1;
    start = 1'b0;
    cfg   = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_qX", int'(qX), 72);
    check_eq("rst_qY", int'(qY), 32);
    check_eq("rst_bomb_id", int'(bomb_id), 0);
    check_eq("rst_vga_x", int'(vga_x), 0);
    check_eq("rst_vga_y", int'(vga_y), 0);
    check_eq("rst_colour", int'(vga_colour), 0);
    check_eq("rst_plot", int'(vga_plot), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    reset = 1'b0;

    // Frame 1: empty floor field.
    p0 = n_plots; c0 = n_col_err; o0 = n_ord_err; d0 = n_dones;
    start_frame(a);
    wait_first_plot("f1_first");
    wait_done(a, "f1");
    @(negedge clk);
    check_eq("f1_done_pulse_width", int'(done), 0);
    check_eq("f1_plots", n_plots - p0, FRAME_PLOTS);
    check_eq("f1_colour_errs", n_col_err - c0, 0);
    check_eq("f1_order_errs", n_ord_err - o0, 0);
    check_eq("f1_dones", n_dones - d0, 1);
    check_eq("f1_last_x", last_x, 247);
    check_eq("f1_last_y", last_y, 207);
    check_eq("f1_floor_pix", int'(img[150][120]), 9'o070);

    // Frame 2: tiles, bombs, explosion; start re-pulsed while busy and on done.
    cfg = 1;
    p0 = n_plots; c0 = n_col_err; o0 = n_ord_err; d0 = n_dones;
    start_frame(a);
    repeat (1000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(a, "f2");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("f2_start_on_done_busy", int'(busy), 0);
    busy_hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    check_eq("f2_no_restart", busy_hi, 0);
    check_eq("f2_plots", n_plots - p0, FRAME_PLOTS);
    check_eq("f2_colour_errs", n_col_err - c0, 0);
    check_eq("f2_order_errs", n_ord_err - o0, 0);
    check_eq("f2_dones", n_dones - d0, 1);
    check_eq("wall_tl", int'(img[88][48]), 9'o444);
    check_eq("wall_br", int'(img[103][63]), 9'o444);
    check_eq("wall_left_nbr", int'(img[87][48]), 9'o070);
    check_eq("soft_tl", int'(img[104][32]), 9'o631);
    check_eq("soft_br", int'(img[119][47]), 9'o631);
    check_eq("power_id7", int'(img[160][120]), 9'o077);
    check_eq("expl_over_bomb", int'(img[124][68]), 9'o740);
    check_eq("bomb_br", int'(img[131][75]), 9'o000);
    check_eq("bomb_in", int'(img[126][70]), 9'o000);
    check_eq("bomb_px3", int'(img[123][68]), 9'o070);
    check_eq("bomb_px12", int'(img[132][75]), 9'o070);
    check_eq("bomb_py12", int'(img[124][76]), 9'o070);
    check_eq("bomb_disabled", int'(img[172][132]), 9'o070);
    check_eq("bomb_near_miss", int'(img[157][100]), 9'o070);

    // Frame 3: reset mid-frame, then restart.
    cfg = 0;
    d0 = n_dones;
    start_frame(a);
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_plot", int'(vga_plot), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_done", int'(done), 0);
    check_eq("abort_qX", int'(qX), 72);
    check_eq("abort_qY", int'(qY), 32);
    reset = 1'b0;
    p0 = n_plots;
    repeat (20) @(negedge clk);
    check_eq("abort_no_plots", n_plots - p0, 0);
    check_eq("abort_no_done", n_dones - d0, 0);
    start_frame(a);
    wait_first_plot("restart_first");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
